wb_write_buffer: RTL
====================

# wb_write_buffer

Writeback buffer sitting directly upstream of the 64-bit RISC-V register file, driving its write port (`W_EN`, `WA`, `WD`). It merges ALU results and load data into one in-order FIFO, drops writes to x0, and paces writes so `W_EN` is never high in two consecutive cycles, because the register file accepts at most one write every two cycles. It also exposes pending-write lookups so the decode/operand stage can forward values not yet committed.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `alu_valid` input 1: ALU result present this cycle.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input 64: ALU result.
- `alu_ready` output 1: ALU result accepted this cycle when `alu_valid` is also high.
- `mem_valid` input 1: load result present; no backpressure.
- `mem_rd` input 5: load destination register.
- `mem_data` input 64: load result.
- `W_EN` output 1: register-file write enable (registered).
- `WA` output 5: register-file write address (registered).
- `WD` output 64: register-file write data (registered).
- `q_ra1`, `q_ra2` input 5 each: forwarding lookup addresses, normally the decoder's RA1 and RA2.
- `fwd1_hit`, `fwd2_hit` output 1 each: a pending write matches the lookup.
- `fwd1_data`, `fwd2_data` output 64 each: the newest pending data for that lookup.
- `busy` output 1: high when `count != 0 || W_EN`.
- `overflow` output 1: sticky error flag.

## Operation
- Write acceptance:
  - A write with rd = 0 is accepted and discarded; it never enters the FIFO and consumes no slot.
  - `alu_ready` = `rst_n && (free slots >= 2)`, computed combinationally from the current count. It reserves room for a simultaneous load.
- Enqueue, same edge, in this order:
  - The mem entry is enqueued first (older).
  - The ALU entry is enqueued second, when `alu_valid && alu_ready`.
  - A maximum of two enqueues per cycle.
- `mem_valid` with nonzero rd while the FIFO is full (after accounting for this cycle's dequeue):
  - The entry is dropped.
  - `overflow` sets and holds until reset.
- Drain:
  - On an edge where `cooldown == 0` and the FIFO is non-empty, the head is popped into `WA`/`WD` and `W_EN` is set to 1.
  - Otherwise `W_EN` is set to 0.
  - `cooldown` is set to 1 on every edge that sets `W_EN`, and cleared on the following edge.
- The dequeue and up to two enqueues in the same edge are all legal. The count update is count + enq − deq.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Count is `log2(DEPTH)+1` bits.
- Forwarding (see Configuration):
  - Candidates, oldest to newest: the output register (only while `W_EN` = 1), then the FIFO entries from head to tail.
  - The newest match wins.
  - Lookup address 0 never hits.
  - Forwarding is purely combinational on current state; entries arriving this cycle are not visible.
- Reset (`rst_n` = 0 at an edge):
  - Cleared to 0: pointers, count, `cooldown`, `W_EN`, `WA`, `WD`, `overflow`.
  - Pending entries are discarded, including in the middle of a burst.
  - `alu_ready` = 0 while `rst_n` is low.
  - Inputs are ignored in the reset cycle.

## Timing
- An entry enqueued at edge k into an empty FIFO with `cooldown` = 0 appears on `W_EN`/`WA`/`WD` after edge k+1. The register file stores it at edge k+2.
- Sustained write rate is one write per two cycles. `W_EN` is never high in two consecutive cycles.
- From edge k (enqueue) until it is written at an edge, an entry is visible to forwarding in every cycle.
- Outputs after reset: `W_EN`=0, `WA`=0, `WD`=0, `overflow`=0, `busy`=0, `fwd*_hit`=0, `fwd*_data`=0.

## Configuration
- `WB_FWD_EN`:
  - Defined: forwarding lookup logic is built as specified.
  - Undefined: `fwd1_hit`/`fwd2_hit` are tied to 0 and `fwd1_data`/`fwd2_data` are tied to 0.
  - The ports exist in both builds; the drain and pacing behaviour is unchanged.

## Test plan
- Reset, then one ALU write of x5=0x1234 at edge 1 -> after edge 2: `W_EN`=1, `WA`=5, `WD`=0x1234. After edge 3: `W_EN`=0. `busy` is 0 after edge 3.
- Three back-to-back ALU writes x1..x3 -> `W_EN` pulses are spaced exactly two cycles apart, in order x1, x2, x3. `W_EN` is never high in two consecutive cycles.
- Same-cycle mem x7=0xAA and ALU x7=0xBB; query `q_ra1`=7 -> `fwd1_data`=0xBB. Writes commit in order 0xAA, then 0xBB.
- ALU write to x0 with `alu_valid` held -> `W_EN` stays 0, count stays 0, `fwd1_hit`=0 for `q_ra1`=0.
- DEPTH=4, continuous ALU traffic -> `alu_ready` drops while free slots < 2. Then `mem_valid` each cycle until full -> `overflow` sets and stays set until `rst_n` is low at an edge.
- Reset asserted with 3 entries pending -> after that edge: count=0, `W_EN`=0, `busy`=0, no further writes. Build without `WB_FWD_EN` -> `fwd*_hit` is always 0.

Source files
------------

// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - in-order writeback buffer pacing 64-bit register-file writes
//
// Merges load results (mem_*) and ALU results (alu_*) into one FIFO, drops
// writes to x0, and drains at most one entry every two cycles onto the
// registered write port W_EN/WA/WD. Pending writes can be looked up for
// operand forwarding; that lookup is built only when WB_FWD_EN is defined,
// otherwise fwd*_hit and fwd*_data are tied to 0.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data      ALU result; alu_ready acknowledges it
//   mem_valid/mem_rd/mem_data      load result, no backpressure
//   W_EN/WA/WD                     registered register-file write port
//   q_ra1/q_ra2                    forwarding lookup addresses
//   fwd1_hit/fwd1_data             newest pending write matching q_ra1
//   fwd2_hit/fwd2_data             newest pending write matching q_ra2
//   busy                           entries pending or a write in flight
//   overflow                       sticky: a load was dropped on a full FIFO

module wb_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [63:0] mem_data,
    output logic        W_EN,
    output logic [4:0]  WA,
    output logic [63:0] WD,
    input  logic [4:0]  q_ra1,
    input  logic [4:0]  q_ra2,
    output logic        fwd1_hit,
    output logic [63:0] fwd1_data,
    output logic        fwd2_hit,
    output logic [63:0] fwd2_data,
    output logic        busy,
    output logic        overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]    rd_mem   [DEPTH];
    logic [63:0]   data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] alu_slot;
    logic [CW-1:0] count;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] occ_after;
    logic          cooldown;
    logic          deq;
    logic          mem_want;
    logic          mem_enq;
    logic          alu_enq;

    always_comb begin
        free_slots = FULL - count;
        // Two free slots are demanded so a same-cycle load always fits
        // alongside an accepted ALU result.
        alu_ready  = rst_n && (free_slots >= CW'(2));
        deq        = !cooldown && (count != '0);
        // The slot freed by this cycle's pop is available to the load.
        occ_after  = count - CW'(deq);
        mem_want   = mem_valid && (mem_rd != 5'd0);
        mem_enq    = mem_want && (occ_after != FULL);
        alu_enq    = alu_valid && alu_ready && (alu_rd != 5'd0);
        // The load is older, so it takes the tail slot and the ALU entry follows.
        alu_slot   = tail + PW'(mem_enq);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (mem_enq) begin
                rd_mem[tail]   <= mem_rd;
                data_mem[tail] <= mem_data;
            end
            if (alu_enq) begin
                rd_mem[alu_slot]   <= alu_rd;
                data_mem[alu_slot] <= alu_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            cooldown <= 1'b0;
            W_EN     <= 1'b0;
            WA       <= '0;
            WD       <= '0;
            overflow <= 1'b0;
        end else begin
            if (deq) begin
                W_EN <= 1'b1;
                WA   <= rd_mem[head];
                WD   <= data_mem[head];
                head <= head + PW'(1);
            end else begin
                W_EN <= 1'b0;
            end
            // A write this edge blocks the next one: the register file
            // accepts one write every two cycles.
            cooldown <= deq;
            tail     <= tail + PW'(mem_enq) + PW'(alu_enq);
            count    <= count + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);
            if (mem_want && !mem_enq) begin
                overflow <= 1'b1;
            end
        end
    end

    assign busy = (count != '0) || W_EN;

`ifdef WB_FWD_EN
    // Scan oldest to newest so the last match, the youngest write, wins.
    function automatic logic [64:0] lookup(input logic [4:0] q);
        logic [64:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        if (q != 5'd0) begin
            if (W_EN && (WA == q)) begin
                r = {1'b1, WD};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if ((CW'(i) < count) && (rd_mem[idx] == q)) begin
                    r = {1'b1, data_mem[idx]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(q_ra1);
        {fwd2_hit, fwd2_data} = lookup(q_ra2);
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{q_ra1, q_ra2};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule
